pipe_stall_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_stall_ctrl_sat_counter.sv | 28 ++
 rtl/pipe_stall_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: controller state
// encodings and the NOP instruction used when a bubble is loaded into a stage register.
package pipe_pkg;

    typedef enum logic [2:0] {
        S_RUN    = 3'd0,
        S_LSTALL = 3'd1,
        S_BFLUSH = 3'd2,
        S_MDWAIT = 3'd3,
        S_DRAIN  = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    // RV32I canonical NOP (addi x0, x0, 0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (inc_i && (count_q != '1))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: stage enables,
// bubble/squash strobes, halt handling and a saturating stall-cycle counter.
module pipe_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES   = 1,
    parameter int BRANCH_FLUSH_CYCLES = 1,
    parameter int MULDIV_TIMEOUT      = 64,
    parameter int DRAIN_CYCLES        = 3,
    parameter int PERF_W              = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_hazard,
    input  logic              branch_taken,
    input  logic              muldiv_start,
    input  logic              muldiv_done,
    input  logic              halt_req,
    input  logic              resume,
    output logic              if_en,
    output logic              id_en,
    output logic              ex_en,
    output logic              mem_en,
    output logic              wb_en,
    output logic              ex_bubble,
    output logic              mem_bubble,
    output logic              flush_if,
    output logic              flush_id,
    output logic              halted,
    output logic              md_timeout_err,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int LW = (LOAD_STALL_CYCLES   > 1) ? $clog2(LOAD_STALL_CYCLES)   : 1;
    localparam int BW = (BRANCH_FLUSH_CYCLES > 1) ? $clog2(BRANCH_FLUSH_CYCLES) : 1;
    localparam int MW = (MULDIV_TIMEOUT      > 1) ? $clog2(MULDIV_TIMEOUT)      : 1;
    localparam int DW = (DRAIN_CYCLES        > 1) ? $clog2(DRAIN_CYCLES)        : 1;

    // Terminal counts; a negative value only arises for a state that is never entered.
    localparam logic [LW-1:0] L_LAST = LW'(LOAD_STALL_CYCLES - 2);
    localparam logic [BW-1:0] B_LAST = BW'(BRANCH_FLUSH_CYCLES - 1);
    localparam logic [MW-1:0] M_LAST = MW'(MULDIV_TIMEOUT - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYCLES - 1);

    state_e        state_q, state_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [MW-1:0] mcnt_q, mcnt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          err_q, err_d;
    logic          md_timeout_hit;

    assign md_timeout_hit = (state_q == S_MDWAIT) && !muldiv_done && (mcnt_q == M_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            lcnt_q  <= '0;
            bcnt_q  <= '0;
            mcnt_q  <= '0;
            dcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            bcnt_q  <= bcnt_d;
            mcnt_q  <= mcnt_d;
            dcnt_q  <= dcnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        // Each counter runs only while its state is occupied and clears otherwise.
        lcnt_d  = (state_q == S_LSTALL) ? lcnt_q + 1'b1 : '0;
        bcnt_d  = (state_q == S_BFLUSH) ? bcnt_q + 1'b1 : '0;
        mcnt_d  = (state_q == S_MDWAIT) ? mcnt_q + 1'b1 : '0;
        dcnt_d  = (state_q == S_DRAIN)  ? dcnt_q + 1'b1 : '0;
        err_d   = err_q | md_timeout_hit;
        case (state_q)
            S_RUN: begin
                if (branch_taken)
                    state_d = (BRANCH_FLUSH_CYCLES > 0) ? S_BFLUSH : S_RUN;
                else if (muldiv_start)
                    state_d = S_MDWAIT;
                else if (load_hazard)
                    state_d = (LOAD_STALL_CYCLES > 1) ? S_LSTALL : S_RUN;
                else if (halt_req)
                    state_d = S_DRAIN;
            end
            S_LSTALL: if (lcnt_q == L_LAST) state_d = S_RUN;
            S_BFLUSH: if (bcnt_q == B_LAST) state_d = S_RUN;
            S_MDWAIT: if (muldiv_done || md_timeout_hit) state_d = S_RUN;
            S_DRAIN:  if (dcnt_q == D_LAST) state_d = S_HALT;
            S_HALT:   if (resume) state_d = S_RUN;
            default:  state_d = S_RUN;
        endcase
    end

    always_comb begin
        if_en      = 1'b1;
        id_en      = 1'b1;
        ex_en      = 1'b1;
        mem_en     = 1'b1;
        wb_en      = 1'b1;
        ex_bubble  = 1'b0;
        mem_bubble = 1'b0;
        flush_if   = 1'b0;
        flush_id   = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_RUN: begin
                if (branch_taken) begin
                    flush_if = 1'b1;
                    flush_id = 1'b1;
                end else if (muldiv_start) begin
                    // issuing cycle proceeds unstalled
                end else if (load_hazard) begin
                    if_en     = 1'b0;
                    id_en     = 1'b0;
                    ex_bubble = 1'b1;
                end else if (halt_req) begin
                    if_en    = 1'b0;
                    flush_if = 1'b1;
                end
            end
            S_LSTALL: begin
                if_en     = 1'b0;
                id_en     = 1'b0;
                ex_bubble = 1'b1;
            end
            S_BFLUSH: flush_if = 1'b1;
            S_MDWAIT: begin
                if (!muldiv_done) begin
                    if_en      = 1'b0;
                    id_en      = 1'b0;
                    ex_en      = 1'b0;
                    mem_bubble = 1'b1;
                end
            end
            S_DRAIN: begin
                if_en     = 1'b0;
                ex_bubble = 1'b1;
            end
            S_HALT: begin
                if_en  = 1'b0;
                id_en  = 1'b0;
                ex_en  = 1'b0;
                mem_en = 1'b0;
                wb_en  = 1'b0;
                halted = 1'b1;
            end
            default: ;
        endcase
    end

    assign md_timeout_err = err_q;

    sat_counter #(
        .W(PERF_W)
    ) u_stall_cnt (
        .clk    (clk),
        .clr_i  (rst),
        .inc_i  (!if_en && !rst),
        .count_o(stall_cycles)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: each driven cycle pushes its expected
// outputs, a monitor pops and compares them mid-cycle.
module tb_pipe_stall_ctrl;

    localparam int PW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_hazard = 1'b0, branch_taken = 1'b0, muldiv_start = 1'b0;
    logic muldiv_done = 1'b0, halt_req = 1'b0, resume = 1'b0;
    logic if_en, id_en, ex_en, mem_en, wb_en, ex_bubble, mem_bubble;
    logic flush_if, flush_id, halted, md_timeout_err;
    logic [PW-1:0] stall_cycles;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .MULDIV_TIMEOUT(8),
        .PERF_W        (PW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_hazard   (load_hazard),
        .branch_taken  (branch_taken),
        .muldiv_start  (muldiv_start),
        .muldiv_done   (muldiv_done),
        .halt_req      (halt_req),
        .resume        (resume),
        .if_en         (if_en),
        .id_en         (id_en),
        .ex_en         (ex_en),
        .mem_en        (mem_en),
        .wb_en         (wb_en),
        .ex_bubble     (ex_bubble),
        .mem_bubble    (mem_bubble),
        .flush_if      (flush_if),
        .flush_id      (flush_id),
        .halted        (halted),
        .md_timeout_err(md_timeout_err),
        .stall_cycles  (stall_cycles)
    );

    // Inputs {rst, load_hazard, branch_taken, muldiv_start, muldiv_done, halt_req, resume}
    localparam logic [6:0] I_NONE = 7'b0000000;
    localparam logic [6:0] I_RST  = 7'b1000000;
    localparam logic [6:0] I_LH   = 7'b0100000;
    localparam logic [6:0] I_BT   = 7'b0010000;
    localparam logic [6:0] I_MS   = 7'b0001000;
    localparam logic [6:0] I_MD   = 7'b0000100;
    localparam logic [6:0] I_HR   = 7'b0000010;
    localparam logic [6:0] I_RS   = 7'b0000001;

    // Outputs {if,id,ex,mem,wb en, ex_bubble, mem_bubble, flush_if, flush_id, halted}
    localparam logic [9:0] O_RUN = 10'b11111_00000;
    localparam logic [9:0] O_LD  = 10'b00111_10000;
    localparam logic [9:0] O_BR  = 10'b11111_00110;
    localparam logic [9:0] O_BF  = 10'b11111_00100;
    localparam logic [9:0] O_MD  = 10'b00011_01000;
    localparam logic [9:0] O_HR  = 10'b01111_00100;
    localparam logic [9:0] O_DR  = 10'b01111_10000;
    localparam logic [9:0] O_HL  = 10'b00000_00001;

    typedef struct {
        logic [10:0]   vec;
        logic [PW-1:0] stall;
    } exp_t;

    exp_t          sb[$];
    logic [PW-1:0] exp_stall = '0;
    logic          exp_err   = 1'b0;
    int            n_checks  = 0;
    int            n_errors  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected stall count follows the expected if_en of earlier cycles.
    task automatic step(input logic [6:0] in, input logic [9:0] exp);
        exp_t e;
        @(negedge clk);
        {rst, load_hazard, branch_taken, muldiv_start, muldiv_done, halt_req, resume} = in;
        e.vec   = {exp, exp_err};
        e.stall = exp_stall;
        sb.push_back(e);
        if (in[6]) begin
            exp_stall = '0;
            exp_err   = 1'b0;
        end else if (!exp[9] && (exp_stall != '1)) begin
            exp_stall = exp_stall + 1'b1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check("outputs", 32'({if_en, id_en, ex_en, mem_en, wb_en, ex_bubble, mem_bubble,
                                  flush_if, flush_id, halted, md_timeout_err}), 32'(e.vec));
            check("stall_cycles", 32'(stall_cycles), 32'(e.stall));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // reset state
        step(I_RST, O_RUN);
        step(I_RST, O_RUN);
        step(I_NONE, O_RUN);

        // single load-use stall
        step(I_LH, O_LD);
        step(I_NONE, O_RUN);
        step(I_NONE, O_RUN);

        // branch wins over load hazard, one flush cycle
        step(I_BT | I_LH, O_BR);
        step(I_NONE, O_BF);
        step(I_NONE, O_RUN);

        // mul/div with done after 5 wait cycles; load hazard ignored while waiting
        step(I_RST, O_RUN);
        step(I_MS, O_RUN);
        step(I_NONE, O_MD);
        step(I_LH, O_MD);
        for (int i = 0; i < 3; i++) step(I_NONE, O_MD);
        step(I_MD, O_RUN);
        step(I_NONE, O_RUN);

        // mul/div timeout; error is sticky until reset
        step(I_RST, O_RUN);
        step(I_MS, O_RUN);
        for (int i = 0; i < 8; i++) step(I_NONE, O_MD);
        exp_err = 1'b1;
        step(I_NONE, O_RUN);
        step(I_LH, O_LD);
        step(I_NONE, O_RUN);
        step(I_RST, O_RUN);
        step(I_NONE, O_RUN);

        // halt: drain ignores other inputs, resume returns to run
        step(I_HR, O_HR);
        step(I_NONE, O_DR);
        step(I_BT, O_DR);
        step(I_MS, O_DR);
        step(I_LH, O_HL);
        step(I_RS, O_HL);
        step(I_NONE, O_RUN);

        // reset in second mul/div wait cycle
        step(I_RST, O_RUN);
        step(I_MS, O_RUN);
        step(I_NONE, O_MD);
        step(I_RST, O_MD);
        step(I_NONE, O_RUN);

        // 20 stall cycles saturate a 4-bit counter at 15
        step(I_HR, O_HR);
        for (int i = 0; i < 3; i++) step(I_NONE, O_DR);
        for (int i = 0; i < 15; i++) step(I_NONE, O_HL);
        step(I_RS, O_HL);
        step(I_NONE, O_RUN);
        step(I_NONE, O_RUN);

        @(negedge clk);
        #5;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
